// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: shared types and constants for the UART bus arbiter.
// Contents: sequencer state encoding, UART register addresses, bus levels.
package uart_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam logic [1:0] REG_TX  = 2'b00;
    localparam logic [1:0] REG_RX  = 2'b01;
    localparam logic [1:0] REG_DIV = 2'b10;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

endpackage

// File: rtl/uart_bus_arbiter_rr.sv
// rr_arbiter: combinational round-robin search for the next grant.
// Ports: i_req   - request vector
//        i_ptr   - index of the last served requester
//        o_valid - at least one request is pending
//        o_idx   - first requester found scanning from i_ptr+1 with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [PW-1:0]      o_idx
);

    // Scan farthest-first so the candidate nearest to i_ptr+1 is written last and wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[PW'((int'(i_ptr) + k) % NUM_REQ)]) begin
                o_valid = 1'b1;
                o_idx   = PW'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin sharing of one UART register port between NUM_REQ requesters.
// Ports: clk, reset       - clock, synchronous active-high reset
//        i_req*           - per-requester request, direction, packed address and write data
//        o_done / o_err   - one-cycle completion / timeout pulse per requester
//        o_rdata          - last read data, valid with o_done
//        o_u_*, i_u_*     - UART side: address, write data, read data, we (LOW = write),
//                           strobe, bus-clock qualifier, acknowledge
module uart_bus_arbiter
    import uart_bus_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT   = 255,
    parameter int READ_HOLD = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_req_we,
    input  logic [2*NUM_REQ-1:0]   i_req_addr,
    input  logic [8*NUM_REQ-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]     o_done,
    output logic [NUM_REQ-1:0]     o_err,
    output logic [7:0]             o_rdata,
    output logic [1:0]             o_u_addr,
    output logic [7:0]             o_u_wdata,
    input  logic [7:0]             i_u_rdata,
    output logic                   o_u_we,
    output logic                   o_u_stb,
    output logic                   o_u_clk,
    input  logic                   i_u_ack
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_grant;
    logic                r_we;
    logic [7:0]          r_timer;
    logic [7:0]          r_hold;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_err;
    logic [7:0]          r_rdata;
    logic [1:0]          r_u_addr;
    logic [7:0]          r_u_wdata;
    logic                r_u_we;
    logic                r_u_stb;
    logic                r_u_clk;

    logic                w_valid;
    logic [PW-1:0]       w_idx;
    logic [1:0]          w_addr  [NUM_REQ];
    logic [7:0]          w_wdata [NUM_REQ];
    logic [7:0]          w_hold_target;
    logic                w_timeout;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = i_req_addr[2*g +: 2];
        assign w_wdata[g] = i_req_wdata[8*g +: 8];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Cycles u_clk stays high once ack is seen: one for writes, plus READ_HOLD for reads.
    assign w_hold_target = r_we ? 8'd1 : 8'(READ_HOLD + 1);
    assign w_timeout     = (r_state == ST_STROBE || r_state == ST_RELEASE) && r_timer == 8'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PW'(NUM_REQ - 1);
            r_grant   <= '0;
            r_we      <= 1'b0;
            r_timer   <= '0;
            r_hold    <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_rdata   <= '0;
            r_u_addr  <= '0;
            r_u_wdata <= '0;
            r_u_we    <= HIGH;
            r_u_stb   <= LOW;
            r_u_clk   <= LOW;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (w_timeout) begin
                r_u_stb <= LOW;
                r_u_clk <= LOW;
                r_err   <= NUM_REQ'(1) << r_grant;
                r_ptr   <= r_grant;
                r_timer <= '0;
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_valid) begin
                            r_grant   <= w_idx;
                            r_we      <= i_req_we[w_idx];
                            r_u_addr  <= w_addr[w_idx];
                            r_u_wdata <= w_wdata[w_idx];
                            r_u_we    <= ~i_req_we[w_idx];
                            r_u_stb   <= HIGH;
                            r_u_clk   <= HIGH;
                            r_timer   <= '0;
                            r_hold    <= '0;
                            r_state   <= ST_STROBE;
                        end
                    end
                    ST_STROBE: begin
                        r_timer <= r_timer + 8'd1;
                        // r_hold != 0 means ack was already seen; keep counting even if it drops.
                        if (i_u_ack || r_hold != '0) begin
                            if (r_hold == w_hold_target) begin
                                r_u_stb <= LOW;
                                r_u_clk <= LOW;
                                r_timer <= '0;
                                r_state <= ST_RELEASE;
                            end else begin
                                r_hold <= r_hold + 8'd1;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        r_timer <= r_timer + 8'd1;
                        if (!i_u_ack) begin
                            if (!r_we)
                                r_rdata <= i_u_rdata;
                            r_done  <= NUM_REQ'(1) << r_grant;
                            r_timer <= '0;
                            r_state <= ST_DONE;
                        end
                    end
                    default: begin
                        r_ptr   <= r_grant;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_rdata   = r_rdata;
    assign o_u_addr  = r_u_addr;
    assign o_u_wdata = r_u_wdata;
    assign o_u_we    = r_u_we;
    assign o_u_stb   = r_u_stb;
    assign o_u_clk   = r_u_clk;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: directed self-checking bench for uart_bus_arbiter.
module tb_uart_bus_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int TIMEOUT   = 255;
    localparam int READ_HOLD = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   req_we = '0;
    logic [2*NUM_REQ-1:0] req_addr = '0;
    logic [8*NUM_REQ-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic [7:0]           rdata;
    logic [1:0]           u_addr;
    logic [7:0]           u_wdata;
    logic [7:0]           u_rdata = '0;
    logic                 u_we;
    logic                 u_stb;
    logic                 u_clk;
    logic                 u_ack = 1'b0;
    logic                 ack_en = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    int done_tot [NUM_REQ];
    int err_tot = 0;
    int hi_tot = 0;
    int order [$];

    always #5 clk = ~clk;

    uart_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .READ_HOLD(READ_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_done      (done),
        .o_err       (err),
        .o_rdata     (rdata),
        .o_u_addr    (u_addr),
        .o_u_wdata   (u_wdata),
        .i_u_rdata   (u_rdata),
        .o_u_we      (u_we),
        .o_u_stb     (u_stb),
        .o_u_clk     (u_clk),
        .i_u_ack     (u_ack)
    );

    // UART model: ack mirrors the strobe shortly after each edge, so the DUT
    // sees it on the following edge.
    initial forever begin
        @(posedge clk);
        #1;
        u_ack = ack_en && u_stb;
    end

    // Monitor: totals of done/err pulses, grant order, and cycles with u_clk and u_ack both high.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done[i]) begin
                    done_tot[i]++;
                    order.push_back(i);
                end
                if (err[i]) err_tot++;
            end
            if (u_clk && u_ack) hi_tot++;
        end
    end

    task automatic wait_done(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = done[idx];
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({done, err, rdata, u_stb, u_clk, u_we, u_addr, u_wdata} !== {2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got done=%b err=%b rdata=%h stb=%b clk=%b we=%b addr=%h wdata=%h, want 0 0 00 0 0 1 0 00",
                     done, err, rdata, u_stb, u_clk, u_we, u_addr, u_wdata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (u_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_no_req: u_stb=%b want 0", u_stb);
        end
    endtask

    task automatic test_write;
        bit ok;
        int d0 = done_tot[0];
        int h0 = hi_tot;
        req_we[0] = 1'b1;
        req_addr[1:0] = 2'b00;
        req_wdata[7:0] = 8'h55;
        req[0] = 1'b1;
        wait_done(0, ok);
        req[0] = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL write_done: no done[0] within budget");
        end
        tests_run++;
        if ({u_we, u_addr, u_wdata, rdata} !== {1'b0, 2'b00, 8'h55, 8'h00}) begin
            tests_failed++;
            $display("FAIL write_bus: got we=%b addr=%h wdata=%h rdata=%h, want 0 0 55 00", u_we, u_addr, u_wdata, rdata);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (done_tot[0] - d0 !== 1) begin
            tests_failed++;
            $display("FAIL write_done_once: got %0d pulses want 1", done_tot[0] - d0);
        end
        // Model ack lags strobe by one cycle, then u_clk stays 1 cycle after ack is seen.
        tests_run++;
        if (hi_tot - h0 !== 2) begin
            tests_failed++;
            $display("FAIL write_clk_hold: got %0d cycles want 2", hi_tot - h0);
        end
    endtask

    task automatic test_read;
        bit ok;
        int h0 = hi_tot;
        req_we[1] = 1'b0;
        req_addr[3:2] = 2'b01;
        u_rdata = 8'hA7;
        req[1] = 1'b1;
        wait_done(1, ok);
        req[1] = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL read_done: no done[1] within budget");
        end
        tests_run++;
        if ({rdata, u_we, u_addr} !== {8'hA7, 1'b1, 2'b01}) begin
            tests_failed++;
            $display("FAIL read_bus: got rdata=%h we=%b addr=%h, want a7 1 1", rdata, u_we, u_addr);
        end
        repeat (5) @(negedge clk);
        // One model-lag cycle plus 1+READ_HOLD cycles after ack is seen.
        tests_run++;
        if (hi_tot - h0 !== 2 + READ_HOLD) begin
            tests_failed++;
            $display("FAIL read_clk_hold: got %0d cycles want %0d", hi_tot - h0, 2 + READ_HOLD);
        end
        u_rdata = 8'h00;
    endtask

    task automatic test_late_change;
        bit ok;
        req_we[0] = 1'b1;
        req_addr[1:0] = 2'b10;
        req_wdata[7:0] = 8'h3C;
        req[0] = 1'b1;
        for (int c = 0; c < 20 && !u_stb; c++) @(negedge clk);
        req_addr[1:0] = 2'b11;
        req_wdata[7:0] = 8'hC3;
        @(negedge clk);
        tests_run++;
        if ({u_addr, u_wdata} !== {2'b10, 8'h3C}) begin
            tests_failed++;
            $display("FAIL late_change_mid: got addr=%h wdata=%h want 2 3c", u_addr, u_wdata);
        end
        wait_done(0, ok);
        req[0] = 1'b0;
        tests_run++;
        if (!ok || {u_addr, u_wdata} !== {2'b10, 8'h3C}) begin
            tests_failed++;
            $display("FAIL late_change_done: ok=%b addr=%h wdata=%h want 1 2 3c", ok, u_addr, u_wdata);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_contention;
        int start;
        int c;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = order.size();
        req_we = '1;
        req = 2'b11;
        for (c = 0; c < 200 && order.size() < start + 4; c++) @(negedge clk);
        req = 2'b00;
        tests_run++;
        if (order.size() < start + 4) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d grants want 4", order.size() - start);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (order[start + i] !== i % 2) begin
                    tests_failed++;
                    $display("FAIL contention_order[%0d]: got %0d want %0d", i, order[start + i], i % 2);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
        int cnt = 0;
        int d0 = done_tot[0];
        logic [7:0] rd0 = rdata;
        ack_en = 1'b0;
        req_we[0] = 1'b1;
        req[0] = 1'b1;
        while (cnt < 400 && !err[0]) begin
            @(negedge clk);
            cnt++;
            if (cnt == 200) begin
                tests_run++;
                if ({u_stb, err} !== {1'b1, 2'b00}) begin
                    tests_failed++;
                    $display("FAIL timeout_waiting: got stb=%b err=%b want 1 00", u_stb, err);
                end
            end
        end
        req[0] = 1'b0;
        // Grant edge, then timer counts 0..TIMEOUT; abort on the edge it equals TIMEOUT.
        tests_run++;
        if (cnt !== TIMEOUT + 2) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", cnt, TIMEOUT + 2);
        end
        tests_run++;
        if ({u_stb, u_clk, rdata} !== {1'b0, 1'b0, rd0} || done_tot[0] !== d0) begin
            tests_failed++;
            $display("FAIL timeout_state: got stb=%b clk=%b rdata=%h dones=%0d want 0 0 %h %0d",
                     u_stb, u_clk, rdata, done_tot[0], rd0, d0);
        end
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        req[0] = 1'b1;
        wait_done(0, ok);
        req[0] = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL timeout_recover: no done[0] after timeout");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int d1 = done_tot[1];
        int e0 = err_tot;
        ack_en = 1'b0;
        req_we[1] = 1'b1;
        req_addr[3:2] = 2'b10;
        req_wdata[15:8] = 8'h99;
        req[1] = 1'b1;
        for (int c = 0; c < 20 && !u_stb; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({done, err, rdata, u_stb, u_clk, u_we, u_addr, u_wdata} !== {2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got done=%b err=%b rdata=%h stb=%b clk=%b we=%b addr=%h wdata=%h, want 0 0 00 0 0 1 0 00",
                     done, err, rdata, u_stb, u_clk, u_we, u_addr, u_wdata);
        end
        req[1] = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (done_tot[1] !== d1 || err_tot !== e0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_pulse: got done+%0d err+%0d want 0 0", done_tot[1] - d1, err_tot - e0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_late_change();
        test_contention();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
